ones_pattern_gen: RTL and testbench

Sequential generator that is the inverse of the design's popcount logic. It accepts a requested ones-count k (0-8) and streams every 8-bit word whose popcount equals k, in strictly ascending numeric order, one word per output handshake. The stream drives exhaustive stimulus into the popcount datapath and is the golden source for its self-check: every emitted word must count to k. It sits between the test/command controller (command side) and the popcount consumer (data side).

---
 rtl/ones_pattern_gen_if.sv | 29 ++
 rtl/ones_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_ones_pattern_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_gen_if.sv
// ones_pattern_gen_if
//   Command and data-stream signals of the ones-count pattern generator.
//   Command side : cmd_valid/cmd_ready handshake, cmd_count (k, 0..8),
//                  cmd_err pulse for an accepted k > 8.
//   Data side    : data_valid/data_ready handshake, data_out (8-bit word
//                  with popcount k), data_last, data_index (0..69).
//   slave  modport : the generator.
//   master modport : the command controller / data consumer.
interface ones_pattern_gen_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_count;
    logic       cmd_err;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_last;
    logic [6:0] data_index;

    modport slave (
        input  cmd_valid, cmd_count, data_ready,
        output cmd_ready, cmd_err, data_valid, data_out, data_last, data_index
    );

    modport master (
        output cmd_valid, cmd_count, data_ready,
        input  cmd_ready, cmd_err, data_valid, data_out, data_last, data_index
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//   Streams every 8-bit word whose popcount equals a requested k (0..8),
//   in ascending numeric order, one word per data handshake.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : ones_pattern_gen_if.slave (command + data stream signals)
//   All outputs are registered.
module ones_pattern_gen (
    input  logic                  clk,
    input  logic                  rst_n,
    ones_pattern_gen_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       cmd_err_q, cmd_err_d;
    logic       data_valid_q, data_valid_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_last_q, data_last_d;
    logic [6:0] data_index_q, data_index_d;

    // Lowest word with k ones: k ones packed at the bottom.
    function automatic logic [7:0] first_word(input logic [3:0] k);
        logic [7:0] mask;
        mask = 8'hFF << k;
        return ~mask;
    endfunction

    // Highest word with k ones: k ones packed at the top.
    function automatic logic [7:0] top_word(input logic [3:0] k);
        logic [7:0] mask;
        mask = 8'hFF >> k;
        return ~mask;
    endfunction

    // Next larger word with the same popcount. The lowest run of ones is
    // carried one place up, and the remaining ones of that run are
    // re-packed at the bottom. The usual divide by the lowest set bit is
    // replaced by a right shift of its position.
    function automatic logic [7:0] next_comb(input logic [7:0] x);
        logic [7:0] low;
        logic [7:0] ripple;
        logic [7:0] ones;
        logic [2:0] tz;
        logic       found;
        low    = x & (~x + 8'd1);
        ripple = x + low;
        tz     = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (x[i] && !found) begin
                tz    = i[2:0];
                found = 1'b1;
            end
        end
        ones = ((ripple ^ x) >> 2) >> tz;
        return ripple | ones;
    endfunction

    logic       cmd_accept;
    logic       data_hs;
    logic [7:0] next_word;

    always_comb begin
        cmd_accept = bus.cmd_valid && cmd_ready_q;
        data_hs    = data_valid_q && bus.data_ready;
        next_word  = next_comb(data_out_q);

        state_d      = state_q;
        k_d          = k_q;
        cmd_ready_d  = 1'b0;
        cmd_err_d    = 1'b0;
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        data_last_d  = data_last_q;
        data_index_d = data_index_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_accept) begin
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_count > 4'd8) begin
                        state_d   = ERR;
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        k_d          = bus.cmd_count;
                        data_valid_d = 1'b1;
                        data_out_d   = first_word(bus.cmd_count);
                        data_index_d = '0;
                        data_last_d  = (first_word(bus.cmd_count) == top_word(bus.cmd_count));
                    end
                end
            end
            RUN: begin
                data_valid_d = 1'b1;
                if (data_hs) begin
                    if (data_last_q) begin
                        state_d      = IDLE;
                        data_valid_d = 1'b0;
                        cmd_ready_d  = 1'b1;
                    end else begin
                        data_out_d   = next_word;
                        data_index_d = data_index_q + 7'd1;
                        data_last_d  = (next_word == top_word(k_q));
                    end
                end
            end
            ERR: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cmd_ready_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            data_last_q  <= 1'b0;
            data_index_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cmd_ready_q  <= cmd_ready_d;
            cmd_err_q    <= cmd_err_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            data_last_q  <= data_last_d;
            data_index_q <= data_index_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.data_valid = data_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_last  = data_last_q;
    assign bus.data_index = data_index_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen
//   Directed command sequence with randomized backpressure and command
//   noise. Expected streams come from enumerating 0..255 and keeping the
//   words whose popcount equals k.
module tb_ones_pattern_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ones_pattern_gen_if bus ();

    ones_pattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model(input int k);
        logic [7:0] w;
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            w = v[7:0];
            if ($countones(w) == k) exp_q.push_back(w);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.cmd_ready !== 1'b1) check("wait_ready_timeout", 32'(bus.cmd_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},  32'(bus.cmd_ready), 0);
        check({tag, "_cmd_err"},    32'(bus.cmd_err), 0);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 0);
        check({tag, "_data_out"},   32'(bus.data_out), 0);
        check({tag, "_data_last"},  32'(bus.data_last), 0);
        check({tag, "_data_index"}, 32'(bus.data_index), 0);
    endtask

    // Issue command k and follow the stream. With stall set, data_ready
    // and cmd_valid/cmd_count are randomized every cycle. abort_at >= 0
    // pulses reset while that index is presented.
    task automatic run_k(input int k, input bit stall, input int abort_at);
        int idx;
        int budget;
        int n;
        bit rdy;
        build_model(k);
        n = exp_q.size();
        wait_ready();
        bus.cmd_valid  = 1'b1;
        bus.cmd_count  = k[3:0];
        bus.data_ready = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_count = 4'($urandom);
        check("start_cmd_ready", 32'(bus.cmd_ready), 0);
        idx = 0;
        budget = 0;
        while (idx < n && budget < 2000) begin
            check($sformatf("k%0d_valid_%0d", k, idx), 32'(bus.data_valid), 1);
            check($sformatf("k%0d_out_%0d", k, idx), 32'(bus.data_out), 32'(exp_q[idx]));
            check($sformatf("k%0d_index_%0d", k, idx), 32'(bus.data_index), idx);
            check($sformatf("k%0d_last_%0d", k, idx), 32'(bus.data_last), (idx == n - 1) ? 1 : 0);
            check($sformatf("k%0d_popcount_%0d", k, idx), $countones(bus.data_out), k);
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("midreset");
                #1;
                rst_n = 1'b1;
                bus.cmd_valid  = 1'b0;
                bus.data_ready = 1'b0;
                return;
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_ready = rdy;
            if (stall) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_count = 4'($urandom);
            end
            tick();
            if (rdy) idx++;
            budget++;
        end
        bus.cmd_valid  = 1'b0;
        bus.data_ready = 1'b0;
        if (idx < n) begin
            check($sformatf("k%0d_stream_timeout", k), idx, n);
        end else begin
            check($sformatf("k%0d_end_valid", k), 32'(bus.data_valid), 0);
            check($sformatf("k%0d_end_cmd_ready", k), 32'(bus.cmd_ready), 1);
        end
    endtask

    task automatic err_k(input int k);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_count = k[3:0];
        tick();
        bus.cmd_valid = 1'b0;
        check($sformatf("err%0d_pulse", k), 32'(bus.cmd_err), 1);
        check($sformatf("err%0d_valid0", k), 32'(bus.data_valid), 0);
        check($sformatf("err%0d_ready0", k), 32'(bus.cmd_ready), 0);
        tick();
        check($sformatf("err%0d_pulse_end", k), 32'(bus.cmd_err), 0);
        check($sformatf("err%0d_valid1", k), 32'(bus.data_valid), 0);
        check($sformatf("err%0d_ready1", k), 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_count  = '0;
        bus.data_ready = 1'b0;
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(bus.cmd_ready), 1);

        run_k(2, 1'b0, -1);
        run_k(0, 1'b0, -1);
        run_k(8, 1'b0, -1);
        run_k(4, 1'b0, -1);
        err_k(9);
        err_k(15);
        run_k(3, 1'b1, -1);
        run_k(5, 1'b0, 10);
        tick();
        check("ready_after_midreset", 32'(bus.cmd_ready), 1);
        run_k(1, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            run_k(int'($urandom_range(0, 8)), 1'b1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
